// File: rtl/wb_multi_project_mux.sv
// wb_multi_project_mux
// Shares one management Wishbone slave port and one IO pad slice among N_PROJ
// wrapped projects.
//   wb_clk_i, wb_rst_ni      : clock, asynchronous active-low reset
//   wbs_*                    : management Wishbone classic slave
//   proj_cyc_o/proj_stb_o    : one-hot strobes to the addressed project
//   proj_we/sel/adr/dat_o    : registered request fields, broadcast
//   proj_ack_i/proj_dat_i    : per-project responses (project k at [32k+31:32k])
//   proj_rst_o               : active-high per-project reset (~enable)
//   io_in/proj_io_in_o       : pad inputs fanned out to all projects
//   proj_io_out_i/oeb_i      : per-project pad drive / enable-bar
//   io_out_o/io_oeb_o        : pad drive / enable-bar of the owning project
// Address slot = wbs_adr_i[23:20]: 0xF is CTRL, < N_PROJ is a project.
// CTRL: [3:0] io_owner, [8+N_PROJ-1:8] enable mask, [31] sticky timeout flag
// (write 1 to clear).
module wb_multi_project_mux #(
    parameter int unsigned N_PROJ  = 4,
    parameter int unsigned IO_W    = 9,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    output logic [N_PROJ-1:0]        proj_cyc_o,
    output logic [N_PROJ-1:0]        proj_stb_o,
    output logic                     proj_we_o,
    output logic [3:0]               proj_sel_o,
    output logic [31:0]              proj_adr_o,
    output logic [31:0]              proj_dat_o,
    input  logic [N_PROJ-1:0]        proj_ack_i,
    input  logic [N_PROJ*32-1:0]     proj_dat_i,
    output logic [N_PROJ-1:0]        proj_rst_o,
    input  logic [IO_W-1:0]          io_in,
    output logic [IO_W-1:0]          proj_io_in_o,
    input  logic [N_PROJ*IO_W-1:0]   proj_io_out_i,
    input  logic [N_PROJ*IO_W-1:0]   proj_io_oeb_i,
    output logic [IO_W-1:0]          io_out_o,
    output logic [IO_W-1:0]          io_oeb_o
);

    localparam logic [31:0] DeadData = 32'hDEAD_BEEF;
    localparam logic [15:0] TmoLast  = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StFwd, StResp} state_t;

    state_t              state_q;
    logic [15:0]         cnt_q;
    logic [3:0]          io_owner_q;
    logic [N_PROJ-1:0]   enable_q;
    logic                tflag_q;
    logic [3:0]          idx_q;
    logic [N_PROJ-1:0]   stb_q;
    logic                we_q;
    logic [3:0]          sel_q;
    logic [31:0]         adr_q;
    logic [31:0]         dat_q;
    logic                ack_q;
    logic [31:0]         rdat_q;
    logic [N_PROJ-1:0]   proj_rst_q;

    // Request decode
    logic [3:0]          slot;
    logic                req;
    logic                is_ctrl;
    logic                proj_hit;
    logic [N_PROJ-1:0]   hit_onehot;
    logic [31:0]         ctrl_val;

    // CTRL write next-state
    logic                ctrl_wr;
    logic [3:0]          owner_wr;
    logic [N_PROJ-1:0]   enable_wr;
    logic [N_PROJ-1:0]   enable_nxt;
    logic                tflag_clr;

    // Response from the addressed project
    logic                fwd_ack;
    logic [31:0]         fwd_dat;

    always_comb begin
        slot       = wbs_adr_i[23:20];
        req        = wbs_cyc_i & wbs_stb_i;
        is_ctrl    = (slot == 4'hF);
        proj_hit   = 1'b0;
        hit_onehot = '0;
        // Only enabled projects are forwarded; disabled ones look unmapped.
        for (int k = 0; k < int'(N_PROJ); k++) begin
            if (slot == 4'(k) && enable_q[k]) begin
                proj_hit      = 1'b1;
                hit_onehot[k] = 1'b1;
            end
        end

        ctrl_val       = '0;
        ctrl_val[3:0]  = io_owner_q;
        for (int i = 0; i < int'(N_PROJ); i++) begin
            ctrl_val[8+i] = enable_q[i];
        end
        ctrl_val[31]   = tflag_q;

        ctrl_wr   = (state_q == StIdle) & req & is_ctrl & wbs_we_i;
        owner_wr  = wbs_sel_i[0] ? wbs_dat_i[3:0] : io_owner_q;
        // Enable bits may span bytes 1 and 2, so each bit follows its own byte lane.
        for (int i = 0; i < int'(N_PROJ); i++) begin
            enable_wr[i] = wbs_sel_i[(8 + i) / 8] ? wbs_dat_i[8+i] : enable_q[i];
        end
        enable_nxt = ctrl_wr ? enable_wr : enable_q;
        tflag_clr  = ctrl_wr & wbs_sel_i[3] & wbs_dat_i[31];

        fwd_ack = 1'b0;
        fwd_dat = '0;
        for (int k = 0; k < int'(N_PROJ); k++) begin
            if (idx_q == 4'(k)) begin
                fwd_ack = proj_ack_i[k];
                fwd_dat = proj_dat_i[32*k +: 32];
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            io_owner_q <= '0;
            enable_q   <= '0;
            tflag_q    <= 1'b0;
            idx_q      <= '0;
            stb_q      <= '0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            ack_q      <= 1'b0;
            rdat_q     <= '0;
            proj_rst_q <= '1;
        end else begin
            enable_q   <= enable_nxt;
            proj_rst_q <= ~enable_nxt;
            if (ctrl_wr) begin
                io_owner_q <= owner_wr;
            end
            unique case (state_q)
                StIdle: begin
                    ack_q  <= 1'b0;
                    rdat_q <= '0;
                    if (req) begin
                        if (is_ctrl) begin
                            if (tflag_clr) begin
                                tflag_q <= 1'b0;
                            end
                            rdat_q  <= wbs_we_i ? 32'h0 : ctrl_val;
                            ack_q   <= 1'b1;
                            state_q <= StResp;
                        end else if (proj_hit) begin
                            idx_q   <= slot;
                            stb_q   <= hit_onehot;
                            we_q    <= wbs_we_i;
                            sel_q   <= wbs_sel_i;
                            adr_q   <= wbs_adr_i;
                            dat_q   <= wbs_dat_i;
                            cnt_q   <= '0;
                            state_q <= StFwd;
                        end else begin
                            // Unmapped or disabled: answer locally, drop writes.
                            rdat_q  <= wbs_we_i ? 32'h0 : DeadData;
                            ack_q   <= 1'b1;
                            state_q <= StResp;
                        end
                    end
                end
                StFwd: begin
                    if (!wbs_cyc_i) begin
                        // Master abandoned the cycle: no ack, flag untouched.
                        stb_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else if (fwd_ack) begin
                        stb_q   <= '0;
                        cnt_q   <= '0;
                        rdat_q  <= we_q ? 32'h0 : fwd_dat;
                        ack_q   <= 1'b1;
                        state_q <= StResp;
                    end else if (cnt_q == TmoLast) begin
                        stb_q   <= '0;
                        cnt_q   <= '0;
                        tflag_q <= 1'b1;
                        rdat_q  <= we_q ? 32'h0 : DeadData;
                        ack_q   <= 1'b1;
                        state_q <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StResp: begin
                    ack_q   <= 1'b0;
                    rdat_q  <= '0;
                    state_q <= StIdle;
                end
                default: begin
                    stb_q   <= '0;
                    ack_q   <= 1'b0;
                    rdat_q  <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = rdat_q;
    assign proj_cyc_o   = stb_q;
    assign proj_stb_o   = stb_q;
    assign proj_we_o    = we_q;
    assign proj_sel_o   = sel_q;
    assign proj_adr_o   = adr_q;
    assign proj_dat_o   = dat_q;
    assign proj_rst_o   = proj_rst_q;
    assign proj_io_in_o = io_in;

    // Pads default to inputs unless an enabled, in-range project owns them.
    always_comb begin
        io_out_o = '0;
        io_oeb_o = '1;
        for (int k = 0; k < int'(N_PROJ); k++) begin
            if (io_owner_q == 4'(k) && enable_q[k]) begin
                io_out_o = proj_io_out_i[IO_W*k +: IO_W];
                io_oeb_o = proj_io_oeb_i[IO_W*k +: IO_W];
            end
        end
    end

endmodule

// File: tb/tb_wb_multi_project_mux.sv
module tb_wb_multi_project_mux;

    localparam int N = 4;
    localparam int W = 9;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]        wbs_sel_i;
    logic [31:0]       wbs_adr_i, wbs_dat_i;
    logic              wbs_ack_o;
    logic [31:0]       wbs_dat_o;
    logic [N-1:0]      proj_cyc_o, proj_stb_o;
    logic              proj_we_o;
    logic [3:0]        proj_sel_o;
    logic [31:0]       proj_adr_o, proj_dat_o;
    logic [N-1:0]      proj_ack_i;
    logic [N*32-1:0]   proj_dat_i;
    logic [N-1:0]      proj_rst_o;
    logic [W-1:0]      io_in, proj_io_in_o;
    logic [N*W-1:0]    proj_io_out_i, proj_io_oeb_i;
    logic [W-1:0]      io_out_o, io_oeb_o;

    always #5 clk = ~clk;

    wb_multi_project_mux #(.N_PROJ(N), .IO_W(W), .TIMEOUT(255)) dut (
        .wb_clk_i      (clk),
        .wb_rst_ni     (rst_n),
        .wbs_cyc_i     (wbs_cyc_i),
        .wbs_stb_i     (wbs_stb_i),
        .wbs_we_i      (wbs_we_i),
        .wbs_sel_i     (wbs_sel_i),
        .wbs_adr_i     (wbs_adr_i),
        .wbs_dat_i     (wbs_dat_i),
        .wbs_ack_o     (wbs_ack_o),
        .wbs_dat_o     (wbs_dat_o),
        .proj_cyc_o    (proj_cyc_o),
        .proj_stb_o    (proj_stb_o),
        .proj_we_o     (proj_we_o),
        .proj_sel_o    (proj_sel_o),
        .proj_adr_o    (proj_adr_o),
        .proj_dat_o    (proj_dat_o),
        .proj_ack_i    (proj_ack_i),
        .proj_dat_i    (proj_dat_i),
        .proj_rst_o    (proj_rst_o),
        .io_in         (io_in),
        .proj_io_in_o  (proj_io_in_o),
        .proj_io_out_i (proj_io_out_i),
        .proj_io_oeb_i (proj_io_oeb_i),
        .io_out_o      (io_out_o),
        .io_oeb_o      (io_oeb_o)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Project responder: acks resp_proj on the resp_delay-th cycle its strobe
    // is seen (-1 = never). noise adds a stray ack on project 3.
    int   resp_proj  = 0;
    int   resp_delay = -1;
    logic noise      = 1'b0;
    int   rcnt       = 0;

    always @(negedge clk) begin
        if (proj_stb_o[resp_proj]) begin
            rcnt       <= rcnt + 1;
            proj_ack_i <= (((rcnt + 1) == resp_delay) ? (4'b0001 << resp_proj) : 4'b0000)
                          | (noise ? 4'b1000 : 4'b0000);
        end else begin
            rcnt       <= 0;
            proj_ack_i <= noise ? 4'b1000 : 4'b0000;
        end
    end

    task automatic start_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel);
        @(negedge clk);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = sel;
    endtask

    // Latency counts negedges after the request was driven; -1 = no ack in 400.
    task automatic wait_ack(output int lat, output logic [31:0] d, output logic [3:0] seen,
                            output int scyc);
        lat  = -1;
        d    = '0;
        seen = '0;
        scyc = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            seen |= proj_stb_o;
            if (proj_stb_o != 0) scyc++;
            if (wbs_ack_o) begin
                lat = i;
                d   = wbs_dat_o;
                break;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
    endtask

    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output int lat, output logic [31:0] d,
                        output logic [3:0] seen, output int scyc);
        start_req(we, adr, dat, sel);
        wait_ack(lat, d, seen, scyc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"},  32'(wbs_ack_o),  32'h0);
        check({tag, "_dat"},  wbs_dat_o,       32'h0);
        check({tag, "_stb"},  32'(proj_stb_o), 32'h0);
        check({tag, "_cyc"},  32'(proj_cyc_o), 32'h0);
        check({tag, "_prst"}, 32'(proj_rst_o), 32'hF);
        check({tag, "_oeb"},  32'(io_oeb_o),   32'h1FF);
        check({tag, "_out"},  32'(io_out_o),   32'h0);
    endtask

    int          lat, scyc;
    logic [31:0] d;
    logic [3:0]  seen;
    int          acks;

    initial begin
        rst_n      = 1'b0;
        wbs_cyc_i  = 1'b0;
        wbs_stb_i  = 1'b0;
        wbs_we_i   = 1'b0;
        wbs_sel_i  = '0;
        wbs_adr_i  = '0;
        wbs_dat_i  = '0;
        io_in      = 9'h15A;
        // Project k pads: out = 37k+5, oeb = 11k+1; data = 0xBAD0_000k except project 1.
        for (int k = 0; k < N; k++) begin
            proj_io_out_i[W*k +: W] = 9'(k * 37 + 5);
            proj_io_oeb_i[W*k +: W] = 9'(k * 11 + 1);
            proj_dat_i[32*k +: 32]  = 32'hBAD0_0000 + 32'(k);
        end
        proj_dat_i[63:32] = 32'h1234_5678;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        check("io_in_fanout", 32'(proj_io_in_o), 32'h15A);

        // CTRL write: owner 2, all enabled
        xfer(1'b1, 32'h00F0_0000, 32'h0000_0F02, 4'hF, lat, d, seen, scyc);
        check("ctrl_wr_lat",  32'(lat),        32'd1);
        check("ctrl_wr_dat",  d,               32'h0);
        check("ctrl_wr_stb",  32'(seen),       32'h0);
        check("ctrl_wr_prst", 32'(proj_rst_o), 32'h0);
        check("io_own2_out",  32'(io_out_o),   32'h04F);
        check("io_own2_oeb",  32'(io_oeb_o),   32'h017);
        xfer(1'b0, 32'h00F0_0010, 32'h0, 4'hF, lat, d, seen, scyc);
        check("ctrl_rd_lat",  32'(lat), 32'd1);
        check("ctrl_rd_dat",  d,        32'h0000_0F02);

        // Project 1 read, ack 3 cycles after strobe, stray ack on project 3
        resp_proj  = 1;
        resp_delay = 4;
        noise      = 1'b1;
        xfer(1'b0, 32'h0010_0040, 32'h0, 4'hF, lat, d, seen, scyc);
        noise      = 1'b0;
        check("p1_lat",  32'(lat),  32'd5);
        check("p1_dat",  d,         32'h1234_5678);
        check("p1_stb",  32'(seen), 32'h2);
        check("p1_scyc", 32'(scyc), 32'd4);

        // Project 0 never acks -> timeout
        resp_proj  = 0;
        resp_delay = -1;
        xfer(1'b0, 32'h0000_0000, 32'h0, 4'hF, lat, d, seen, scyc);
        check("tmo_lat",  32'(lat),  32'd256);
        check("tmo_scyc", 32'(scyc), 32'd255);
        check("tmo_stb",  32'(seen), 32'h1);
        check("tmo_dat",  d,         32'hDEAD_BEEF);
        xfer(1'b0, 32'h00F0_0000, 32'h0, 4'hF, lat, d, seen, scyc);
        check("tmo_flag", d, 32'h8000_0F02);
        xfer(1'b1, 32'h00F0_0000, 32'h8000_0000, 4'h8, lat, d, seen, scyc);
        check("clr_lat", 32'(lat), 32'd1);
        xfer(1'b0, 32'h00F0_0000, 32'h0, 4'hF, lat, d, seen, scyc);
        check("clr_flag", d, 32'h0000_0F02);

        // Owner 5 (out of range), project 3 disabled
        xfer(1'b1, 32'h00F0_0000, 32'h0000_0705, 4'h3, lat, d, seen, scyc);
        check("dis_prst",    32'(proj_rst_o), 32'h8);
        check("own5_out",    32'(io_out_o),   32'h0);
        check("own5_oeb",    32'(io_oeb_o),   32'h1FF);
        xfer(1'b0, 32'h0070_0000, 32'h0, 4'hF, lat, d, seen, scyc);
        check("unmap_lat",   32'(lat),  32'd1);
        check("unmap_dat",   d,         32'hDEAD_BEEF);
        check("unmap_stb",   32'(seen), 32'h0);
        xfer(1'b0, 32'h0030_0004, 32'h0, 4'hF, lat, d, seen, scyc);
        check("dis3_lat",    32'(lat),  32'd1);
        check("dis3_dat",    d,         32'hDEAD_BEEF);
        check("dis3_stb",    32'(seen), 32'h0);
        xfer(1'b1, 32'h0030_0004, 32'hCAFE_F00D, 4'hF, lat, d, seen, scyc);
        check("dis3_wr_lat", 32'(lat),  32'd1);
        check("dis3_wr_dat", d,         32'h0);
        check("dis3_wr_stb", 32'(seen), 32'h0);
        xfer(1'b1, 32'h00F0_0000, 32'h0000_0001, 4'h1, lat, d, seen, scyc);
        check("own1_out",    32'(io_out_o), 32'h02A);
        check("own1_oeb",    32'(io_oeb_o), 32'h00C);

        // Master drops cyc in FWD cycle 2
        resp_proj  = 1;
        resp_delay = -1;
        start_req(1'b1, 32'h0010_0008, 32'hA5A5_0001, 4'h3);
        @(negedge clk);
        check("drop_stb1", 32'(proj_stb_o), 32'h2);
        check("drop_adr",  proj_adr_o,      32'h0010_0008);
        check("drop_wdat", proj_dat_o,      32'hA5A5_0001);
        check("drop_sel",  32'(proj_sel_o), 32'h3);
        check("drop_we",   32'(proj_we_o),  32'h1);
        @(negedge clk);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        @(negedge clk);
        check("drop_stb_low", 32'(proj_stb_o), 32'h0);
        acks = 0;
        repeat (5) begin
            @(negedge clk);
            if (wbs_ack_o) acks++;
        end
        check("drop_no_ack", 32'(acks), 32'h0);
        xfer(1'b0, 32'h00F0_0000, 32'h0, 4'hF, lat, d, seen, scyc);
        check("drop_ctrl", d, 32'h0000_0701);

        // Reset in FWD
        start_req(1'b0, 32'h0010_0000, 32'h0, 4'hF);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_fwd");
        @(negedge clk);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        rst_n     = 1'b1;
        acks = 0;
        repeat (5) begin
            @(negedge clk);
            if (wbs_ack_o) acks++;
        end
        check("rst_no_ack", 32'(acks), 32'h0);
        xfer(1'b0, 32'h00F0_0000, 32'h0, 4'hF, lat, d, seen, scyc);
        check("rst_ctrl", d, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_multi_project_mux.md
WB_MULTI_PROJECT_MUX -- requirements
Module: wb_multi_project_mux

Interface
REQ-001 Parameter N_PROJ, default 4, number of wrapped projects sharing the Wishbone bus and IO pads (1..15).
REQ-002 Parameter IO_W, default 9, width of the shared IO pad slice.
REQ-003 Parameter TIMEOUT, default 255, max project-response wait in cycles (1..65535).
REQ-004 wb_clk_i  in  1  sole clock; all logic rising-edge.
REQ-005 wb_rst_ni  in  1  asynchronous, active-low reset.
REQ-006 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  MGMT Wishbone classic slave controls.
REQ-007 wbs_sel_i  in  4;  wbs_adr_i  in  32;  wbs_dat_i  in  32  MGMT request fields.
REQ-008 wbs_ack_o  out  1;  wbs_dat_o  out  32  MGMT response.
REQ-009 proj_cyc_o, proj_stb_o  out  N_PROJ  one-hot per-project strobes.
REQ-010 proj_we_o 1, proj_sel_o 4, proj_adr_o 32, proj_dat_o 32  out  request fields broadcast to all projects.
REQ-011 proj_ack_i  in  N_PROJ;  proj_dat_i  in  N_PROJ*32  per-project responses, project k at bits [32k+31:32k].
REQ-012 proj_rst_o  out  N_PROJ  active-high per-project reset.
REQ-013 io_in  in  IO_W;  proj_io_in_o  out  IO_W  pad inputs fanned to every project.
REQ-014 proj_io_out_i, proj_io_oeb_i  in  N_PROJ*IO_W  per-project pad drive/enable.
REQ-015 io_out_o, io_oeb_o  out  IO_W  muxed pad drive and output-enable-bar.

Function
REQ-016 Slot decode: slot = wbs_adr_i[23:20]; slot 0xF = control register; slot < N_PROJ = project; any other slot = unmapped.
REQ-017 Control register CTRL (slot 0xF, any offset): [3:0] io_owner RW; [8+N_PROJ-1:8] enable mask RW; [31] timeout_flag, read 1 = sticky, write 1 clears; other bits read 0.
REQ-018 CTRL write honours wbs_sel_i per byte; timeout_flag cleared only when wbs_sel_i[3]=1 and wbs_dat_i[31]=1.
REQ-019 FSM states IDLE, FWD, RESP.
REQ-020 IDLE, cyc&stb to CTRL or unmapped: perform access, go RESP; wbs_ack_o high exactly the next cycle (latency 1).
REQ-021 Unmapped or disabled-project (enable bit 0) access: no forwarding, read data 0xDEADBEEF, writes dropped, ack at latency 1.
REQ-022 IDLE, cyc&stb to enabled project k: register request fields, enter FWD, assert proj_cyc_o[k]/proj_stb_o[k] from next cycle; all other strobes stay 0.
REQ-023 FWD: proj_ack_i[k] seen -> latch proj_dat_i slot k, drop strobes, go RESP; master ack one cycle after project ack.
REQ-024 FWD: 16-bit wait counter; reaching TIMEOUT cycles without project ack -> drop strobes, set timeout_flag, RESP with data 0xDEADBEEF.
REQ-025 FWD: wbs_cyc_i falls before completion -> drop strobes, return to IDLE, no wbs_ack_o, flag unchanged.
REQ-026 RESP: wbs_ack_o=1 for exactly one cycle, wbs_dat_o valid that cycle (0 on writes); then IDLE; new request not accepted in RESP cycle.
REQ-027 proj_ack_i from non-addressed projects, or outside FWD, ignored.
REQ-028 proj_rst_o[k] = ~enable[k], registered; clearing enable bit during FWD to that project does not abort; timeout rule applies.
REQ-029 IO mux: io_owner < N_PROJ and enable[io_owner]=1 -> io_out_o/io_oeb_o = that project's slice; otherwise io_out_o = 0, io_oeb_o = all 1 (pads input).
REQ-030 IO mux combinational from registered io_owner/enable; proj_io_in_o = io_in unregistered.

Reset
REQ-031 Asynchronous on wb_rst_ni low: FSM IDLE, counter 0, io_owner 0, enable mask 0, timeout_flag 0.
REQ-032 During/after reset: wbs_ack_o 0, wbs_dat_o 0, all proj_cyc_o/proj_stb_o 0, proj_rst_o all 1, io_oeb_o all 1, io_out_o 0.
REQ-033 Reset mid-transaction discards it; no ack issued after release.

Verification
REQ-034 Write CTRL 0x0000_0F02 sel=0xF -> ack at latency 1; proj_rst_o=0; pads follow project 2; readback 0x0000_0F02.
REQ-035 Enabled project 1 read, project acks 3 cycles after strobe with 0x1234_5678 -> proj_stb_o[1] only; wbs_ack_o one cycle later, data 0x1234_5678.
REQ-036 Read enabled project 0 that never acks, TIMEOUT=255 -> ack after 255 FWD cycles, data 0xDEADBEEF, CTRL[31]=1; write 0x8000_0000 sel=0x8 clears it.
REQ-037 Read slot 0x7 (unmapped) and disabled project 3 -> no strobes, ack latency 1, data 0xDEADBEEF.
REQ-038 Drop wbs_cyc_i in FWD cycle 2 -> strobes low next cycle, no ack; wb_rst_ni low in FWD -> all outputs at REQ-032 values immediately.
